alu_share_arbiter: RTL and testbench

//  Shares one 8-bit ALU datapath (AND/OR/ADD/SUB, zero flag) between NREQ requesters.

---
 rtl/alu_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one WIDTH-bit ALU (AND/OR/ADD/SUB, zero flag) between NREQ requesters.
//   A round-robin arbiter picks one valid request per cycle. The chosen operation is
//   evaluated and captured in a single-entry response register, which holds its
//   result until the consumer takes it (rsp_valid & rsp_ready).
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req_valid   per-requester request strobe
//   req_ready   per-requester accept (one-hot or zero, purely combinational)
//   req_op      3-bit op of requester i at [3i+2:3i]
//   req_a/b     operands of requester i at [WIDTH*i +: WIDTH]
//   rsp_valid   response register holds a result
//   rsp_ready   consumer takes the response this cycle
//   rsp_id      index of the requester that issued the op
//   rsp_result  ALU result (0 for illegal ops)
//   rsp_zero    result == 0 for legal ops
//   rsp_err     op code was illegal (1xx)

module alu_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    // Derived; do not override.
    parameter int unsigned ID_W  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [3*NREQ-1:0]      req_op,
    input  logic [WIDTH*NREQ-1:0]  req_a,
    input  logic [WIDTH*NREQ-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_err
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [WIDTH-1:0]  rsp_result_q;
    logic              rsp_zero_q;
    logic              rsp_err_q;

    // Arbitration
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              accept;
    int unsigned       arb_idx;

    // Rotating search starting just after the last grant; first valid wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        arb_idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!any_valid) begin
                arb_idx = (32'(last_grant_q) + k) % NREQ;
                if (req_valid[arb_idx]) begin
                    any_valid = 1'b1;
                    winner    = ID_W'(arb_idx);
                end
            end
        end
    end

    // rst_n gates accept so nothing is granted while reset is being applied.
    always_comb begin
        accept = rst_n & any_valid & ((state_q == StEmpty) | rsp_ready);
    end

    always_comb begin
        req_ready         = '0;
        req_ready[winner] = accept;
    end

    // Shared ALU on the winner's operands
    logic [2:0]        alu_op;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_res;
    logic              alu_err, alu_zero;

    always_comb begin
        alu_op = req_op[3*32'(winner) +: 3];
        alu_a  = req_a[WIDTH*32'(winner) +: WIDTH];
        alu_b  = req_b[WIDTH*32'(winner) +: WIDTH];
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        unique case (alu_op)
            3'b000:  alu_res = alu_a & alu_b;
            3'b001:  alu_res = alu_a | alu_b;
            3'b010:  alu_res = alu_a + alu_b;
            3'b011:  alu_res = alu_a - alu_b;
            default: alu_err = 1'b1;
        endcase
        alu_zero = !alu_err && (alu_res == '0);
    end

    // Response register FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (rsp_ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            last_grant_q <= ID_W'(NREQ - 1);
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= winner;
                rsp_id_q     <= winner;
                rsp_result_q <= alu_res;
                rsp_zero_q   <= alu_zero;
                rsp_err_q    <= alu_err;
            end
        end
    end

    always_comb begin
        rsp_valid  = (state_q == StFull);
        rsp_id     = rsp_id_q;
        rsp_result = rsp_result_q;
        rsp_zero   = rsp_zero_q;
        rsp_err    = rsp_err_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by constrained-random
// traffic, all checked against a transaction-level reference model.

module tb_alu_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [3*NREQ-1:0]      req_op;
    logic [WIDTH*NREQ-1:0]  req_a;
    logic [WIDTH*NREQ-1:0]  req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_zero;
    logic                   rsp_err;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: contents of the response slot and the round-robin pointer.
    int              m_last;
    bit              m_full;
    bit              m_show;   // slot contents are defined (after reset or a grant)
    int              m_id, m_res;
    bit              m_zero, m_err;
    logic [NREQ-1:0] granted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ref_alu(input int op, input int a, input int b,
                           output int res, output bit err);
        err = 1'b0;
        case (op)
            0: res = a & b;
            1: res = a | b;
            2: res = (a + b) % (2 ** WIDTH);
            3: res = (a - b + (2 ** WIDTH)) % (2 ** WIDTH);
            default: begin res = 0; err = 1'b1; end
        endcase
    endtask

    // One clock cycle: inputs already driven; check grant, clock, check response.
    task automatic step();
        int              win;
        bit              acc;
        logic [NREQ-1:0] exp_ready;
        int              res;
        bit              err;
        #1;
        exp_ready = '0;
        win = -1;
        acc = 1'b0;
        res = 0;
        err = 1'b0;
        if (rst_n) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (m_last + k) % NREQ;
                if (win < 0 && req_valid[idx]) win = idx;
            end
            acc = (win >= 0) && (!m_full || rsp_ready);
            if (acc) exp_ready[win] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        granted = req_valid & exp_ready;
        if (acc) ref_alu(int'(req_op[3*win +: 3]), int'(req_a[WIDTH*win +: WIDTH]),
                         int'(req_b[WIDTH*win +: WIDTH]), res, err);
        @(posedge clk);
        if (!rst_n) begin
            m_full = 0; m_last = NREQ - 1; m_id = 0; m_res = 0;
            m_zero = 0; m_err = 0; m_show = 1;
        end else if (acc) begin
            m_full = 1; m_last = win; m_id = win; m_res = res;
            m_err = err; m_zero = !err && (res == 0); m_show = 1;
        end else if (m_full && rsp_ready) begin
            m_full = 0; m_show = 0;
        end
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_show) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_result", 32'(rsp_result), 32'(m_res));
            check("rsp_zero", 32'(rsp_zero), 32'(m_zero));
            check("rsp_err", 32'(rsp_err), 32'(m_err));
        end
    endtask

    task automatic set_req(input int i, input bit v, input int op, input int a, input int b);
        req_valid[i]            = v;
        req_op[3*i +: 3]        = 3'(op);
        req_a[WIDTH*i +: WIDTH] = WIDTH'(a);
        req_b[WIDTH*i +: WIDTH] = WIDTH'(b);
    endtask

    // Requesters hold a pending request until granted; others get fresh traffic.
    task automatic random_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (!(req_valid[i] && !granted[i]))
                set_req(i, bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        m_last = NREQ - 1; m_full = 0; m_show = 0;
        m_id = 0; m_res = 0; m_zero = 0; m_err = 0;
        granted   = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // 1. Reset with every requester asking.
        rst_n     = 1'b0;
        req_valid = '1;
        step();
        step();
        check("reset_valid", 32'(rsp_valid), 32'd0);

        // 2. Requester 1 ADD 200+100 wraps to 44.
        rst_n     = 1'b1;
        req_valid = '0;
        set_req(1, 1, 3'b010, 200, 100);
        step();
        check("add_result", 32'(rsp_result), 32'd44);
        check("add_id", 32'(rsp_id), 32'd1);
        req_valid = '0;
        step();

        // 3. Requester 2 SUB: 5-5 -> zero, 3-5 -> 254.
        set_req(2, 1, 3'b011, 5, 5);
        step();
        check("sub_zero", 32'(rsp_zero), 32'd1);
        set_req(2, 1, 3'b011, 3, 5);
        step();
        check("sub_wrap", 32'(rsp_result), 32'd254);
        req_valid = '0;
        step();

        // 4. Fresh pointer, all four held valid: ids 0,1,2,3,0,1 back-to-back.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, i, 16 * i + 3, 7);
        rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            check("rr_seq", 32'(rsp_id), 32'(n % NREQ));
        end

        // 5. Backpressure for three cycles, then release.
        rsp_ready = 1'b0;
        for (int n = 0; n < 3; n++) step();
        check("bp_hold_id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        step();
        check("bp_next_id", 32'(rsp_id), 32'd2);

        // 6. Illegal op from requester 0, then reset while FULL.
        req_valid = '0;
        step();
        set_req(0, 1, 3'b101, 9, 9);
        step();
        check("illegal_err", 32'(rsp_err), 32'd1);
        check("illegal_res", 32'(rsp_result), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        check("rst_full_valid", 32'(rsp_valid), 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '1;
        step();
        check("rst_prio_id", 32'(rsp_id), 32'd0);

        // Random traffic with random backpressure and rare resets.
        for (int n = 0; n < 400; n++) begin
            random_reqs();
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
